// File: rtl/csa_resolve_seq.sv
// rtl/csa_resolve_seq.sv - sequential chunked carry-propagate adder resolving a carry-save pair (optional CSA_RESOLVE_ZERO_DET_EN adds out_zero)
module csa_resolve_seq #(
  parameter int WIDTH = 45,
  parameter int CHUNK = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CSA_RESOLVE_ZERO_DET_EN
  output logic             out_zero,
`endif
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_width_check
      $error("csa_resolve_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] s_q;
  logic             carry;
  logic             accept;
  logic             last_chunk;
  logic [31:0]      base;
  logic [CHUNK-1:0] c_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK:0]   chunk_add;
`ifdef CSA_RESOLVE_ZERO_DET_EN
  logic             zero_acc;
`endif

  // Current chunk slice and its ripple add including the registered carry
  always_comb begin
    base       = 32'(idx) * 32'(CHUNK);
    c_chunk    = c_q[base +: CHUNK];
    s_chunk    = s_q[base +: CHUNK];
    chunk_add  = {1'b0, c_chunk} + {1'b0, s_chunk} + {{CHUNK{1'b0}}, carry};
    last_chunk = (idx == LAST_IDX);
  end

  // Next-state and handshake decode; ready/valid are pure functions of state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, per-chunk add, carry chaining and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      c_q   <= '0;
      s_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef CSA_RESOLVE_ZERO_DET_EN
      zero_acc <= 1'b1;
      out_zero <= 1'b0;
`endif
    end else if (accept) begin
      c_q   <= c;
      s_q   <= s;
      carry <= 1'b0;
      idx   <= '0;
`ifdef CSA_RESOLVE_ZERO_DET_EN
      zero_acc <= 1'b1;
`endif
    end else if (state == ADD) begin
      sum[base +: CHUNK] <= chunk_add[CHUNK-1:0];
      carry              <= chunk_add[CHUNK];
`ifdef CSA_RESOLVE_ZERO_DET_EN
      zero_acc <= zero_acc & (chunk_add[CHUNK-1:0] == '0);
`endif
      if (last_chunk) begin
        cout <= chunk_add[CHUNK];
        idx  <= '0;
`ifdef CSA_RESOLVE_ZERO_DET_EN
        out_zero <= zero_acc & (chunk_add[CHUNK-1:0] == '0);
`endif
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb/tb_csa_resolve_seq.sv - directed self-checking bench for csa_resolve_seq
module tb_csa_resolve_seq;

  localparam int W = 45;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] c = '0;
  logic [W-1:0] s = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_RESOLVE_ZERO_DET_EN
  logic         out_zero;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  csa_resolve_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CSA_RESOLVE_ZERO_DET_EN
    .out_zero  (out_zero),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, accept one pair, wait for the result, check it, consume it.
  task automatic run_op(input string tag, input logic [W-1:0] cv, input logic [W-1:0] sv,
                        input logic [W-1:0] esum, input logic ecout, input logic ezero);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    c = cv;
    s = sv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd3);
    chk({tag, "_sum"}, 64'(sum), 64'(esum));
    chk({tag, "_cout"}, 64'(cout), 64'(ecout));
`ifdef CSA_RESOLVE_ZERO_DET_EN
    chk({tag, "_zero"}, 64'(out_zero), 64'(ezero));
`else
    if (ezero) n = 0;
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int last_acc;
    logic [W:0]   ref_full;
    logic [W-1:0] rc;
    logic [W-1:0] rs;
    logic [W-1:0] held_sum;
    logic         held_cout;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
`ifdef CSA_RESOLVE_ZERO_DET_EN
    chk("rst_zero", 64'(out_zero), 64'd0);
`endif

    // Directed arithmetic vectors
    run_op("chunk_carry", 45'h7FFF, 45'h1, 45'h8000, 1'b0, 1'b0);
    run_op("two_chunk_carry", 45'h3FFF_FFFF, 45'h1, 45'h4000_0000, 1'b0, 1'b0);
    run_op("full_wrap", 45'h1FFF_FFFF_FFFF, 45'h1, 45'h0, 1'b1, 1'b1);
    run_op("max_ops", 45'h1FFF_FFFF_FFFF, 45'h1FFF_FFFF_FFFF, 45'h1FFF_FFFF_FFFE, 1'b1, 1'b0);
    run_op("zero_ops", 45'h0, 45'h0, 45'h0, 1'b0, 1'b1);
    run_op("odd_lsb", 45'h1_0000_0001, 45'h0_8000_0001, 45'h1_8000_0002, 1'b0, 1'b0);

    // Backpressure: result held while consumer stalls and inputs wiggle
    c = 45'h1234_5678;
    s = 45'h1111_1111;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_lat", 64'(n), 64'd3);
    chk("bp_sum0", 64'(sum), 64'h2345_6789);
    held_sum  = sum;
    held_cout = cout;
    for (int i = 0; i < 5; i++) begin
      c = 45'(i * 32'h0101_0101);
      s = ~c;
      in_valid = i[0];
      step();
      chk("bp_sum_hold", 64'(sum), 64'(held_sum));
      chk("bp_cout_hold", 64'(cout), 64'(held_cout));
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    run_op("bp_next", 45'h100, 45'h200, 45'h300, 1'b0, 1'b0);

    // Reset while in ADD at chunk index 1
    c = 45'h1FFF_FFFF_FFFF;
    s = 45'h1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    run_op("after_rst", 45'h123, 45'h456, 45'h579, 1'b0, 1'b0);

    // Back-to-back random pairs with the consumer always ready
    out_ready = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 100; i++) begin
      rc = {$urandom, $urandom};
      rs = {$urandom, $urandom};
      if (i == 0) rc = 45'h1FFF_FFFF_FFFF;
      ref_full = {1'b0, rc} + {1'b0, rs};
      c = rc;
      s = rs;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) chk("b2b_ready_timeout", 64'(in_ready), 64'd1);
      if (i > 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'd5);
      last_acc = cyc;
      step();
      c = ~rc;
      s = ~rs;
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
      chk("b2b_sum", 64'(sum), 64'(ref_full[W-1:0]));
      chk("b2b_cout", 64'(cout), 64'(ref_full[W]));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_resolve_seq.md
Name: csa_resolve_seq

Overview:
Converts a carry-save pair (c, s), as produced by the 3:2 compressor stages, back into a plain binary sum. It uses a sequential, chunked carry-propagate adder.
- Sits at the tail of the multiplier/reduction datapath, ahead of any consumer that needs non-redundant operands.
- Trades latency for area: one CHUNK-bit ripple add per cycle.
- Valid/ready handshake on both sides.

Parameters:
WIDTH, 45, operand width of c, s and sum.
CHUNK, 15, bits added per cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails (generate-time $error).
NCHUNK, WIDTH/CHUNK (localparam), number of add cycles.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  c/s presented
in_ready  out  1  block can accept; high only in IDLE
c  in  WIDTH  carry vector (weights as given, no internal shift)
s  in  WIDTH  sum vector
out_valid  out  1  result valid; held until accepted
out_ready  in  1  consumer accepts result
sum  out  WIDTH  (c + s) mod 2^WIDTH
cout  out  1  bit WIDTH of c + s

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; out_valid=0; sum=0; cout=0; internal carry=0; chunk index=0.
  - in_ready=1 after reset, because it is decoded from state.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch c and s into operand registers, clear the carry, set index=0, go to ADD.
  - ADD: each cycle, compute {carry', sum[i*CHUNK +: CHUNK]} = c_chunk + s_chunk + carry, then index++. After the index=NCHUNK-1 cycle, load cout=carry' and go to DONE.
  - DONE: out_valid=1; sum/cout stable. On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept at edge T; out_valid is high after edge T+NCHUNK (3 cycles at default).
  - Next accept no earlier than edge T+NCHUNK+2 (the cycle after out handshake), giving a sustained throughput of 1 result per NCHUNK+2 cycles.
- Handshake rules:
  - No overlap: in_ready=0 in ADD and DONE regardless of out_ready.
  - c and s are sampled only at the accept edge; input changes afterwards are ignored.
  - out_valid never deasserts without out_ready; sum/cout do not change while out_valid=1.
  - in_valid while not ready is ignored and is not queued.
- Arithmetic:
  - Unsigned, full WIDTH on both operands.
  - No assumption that c[0]=0.
  - Carry ripples across chunk boundaries through the registered carry only.
  - Max case: c=s=2^WIDTH-1 gives sum=2^WIDTH-2, cout=1.
- Reset mid-operation (in ADD or DONE): immediate return to IDLE; pending result discarded; out_valid=0 the cycle after the reset edge.
- sum register: partial chunks are written during ADD. The sum output is only meaningful when out_valid=1.

Optional Feature:
Macro CSA_RESOLVE_ZERO_DET_EN.
- Defined:
  - Adds output port out_zero (1 bit, reset 0).
  - In ADD, an accumulating flag tracks whether every written chunk is all-zero. It is cleared on accept.
  - out_zero is registered into DONE together with cout: 1 iff sum==0 mod 2^WIDTH. cout is not considered.
  - Valid only with out_valid.
- Undefined: no port, no extra logic; all other behaviour identical.

Test Plan:
- Chunk-boundary carry: c=0x7FFF, s=0x1 -> sum=0x8000, cout=0; out_valid rises 3 edges after accept.
- Full wrap: c=0x1FFF_FFFF_FFFF, s=0x1 -> sum=0, cout=1; out_zero=1 when CSA_RESOLVE_ZERO_DET_EN is defined.
- Max operands: c=s=0x1FFF_FFFF_FFFF -> sum=0x1FFF_FFFF_FFFE, cout=1, out_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling c/s/in_valid meanwhile -> sum/cout stable, in_ready=0 throughout; accept on cycle 6, next input accepted the following cycle.
- Reset in ADD: assert rst for 1 cycle at chunk index 1 -> out_valid=0, in_ready=1 next cycle; a subsequent c=0x123, s=0x456 gives sum=0x579.
- Back-to-back with out_ready=1 and 100 random pairs -> each result matches the (c+s) reference model; accept spacing is exactly 5 cycles.
